// File: rtl/mpu_seq_engine_pkg.sv
// mpu_pkg: shared definitions for the sequential matrix processing unit.
//   - opcode constants (OP_ADD..OP_MUL), FSM state enum
//   - idx(): bit offset of element (r,c) inside a packed N*N*W matrix
package mpu_pkg;

    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_IMUL      = 3'd2;
    localparam logic [2:0] OP_OPP       = 3'd3;
    localparam logic [2:0] OP_TRANSPOSE = 3'd4;
    localparam logic [2:0] OP_MUL       = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int idx(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

    // Opcodes 5 and 7 are reserved.
    function automatic logic op_valid(input logic [2:0] op);
        return (op != 3'd5) && (op != 3'd7);
    endfunction

endpackage

// File: rtl/mpu_seq_engine_if.sv
// Command/result bundle between the host and the matrix engine.
//   master: host side (drives start/operation/size/factor/matrices)
//   slave : engine side (drives busy/done/error/overflow/result)
interface mpu_seq_engine_if #(
    parameter int N = 5,
    parameter int W = 8
);
    localparam int SW = $clog2(N + 1);

    logic                  start;
    logic [2:0]            operation;
    logic [SW-1:0]         size;
    logic signed [W-1:0]   factor;
    logic [N*N*W-1:0]      matrix_a;
    logic [N*N*W-1:0]      matrix_b;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  overflow;
    logic [N*N*W-1:0]      result;

    modport master (
        output start, operation, size, factor, matrix_a, matrix_b,
        input  busy, done, error, overflow, result
    );

    modport slave (
        input  start, operation, size, factor, matrix_a, matrix_b,
        output busy, done, error, overflow, result
    );
endinterface

// File: rtl/mpu_seq_engine_saturate.sv
// mpu_saturate: signed narrowing clamp from IW to W bits.
//   din_i  : wide signed value
//   dout_o : value clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf_o  : high when a clamp happened
module mpu_saturate #(
    parameter int W  = 8,
    parameter int IW = 19
) (
    input  logic signed [IW-1:0] din_i,
    output logic signed [W-1:0]  dout_o,
    output logic                 ovf_o
);
    localparam logic signed [IW-1:0] MAXV = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-W+1){1'b1}}, {(W-1){1'b0}}};

    always_comb begin
        dout_o = din_i[W-1:0];
        ovf_o  = 1'b0;
        if (din_i > MAXV) begin
            dout_o = MAXV[W-1:0];
            ovf_o  = 1'b1;
        end else if (din_i < MINV) begin
            dout_o = MINV[W-1:0];
            ovf_o  = 1'b1;
        end
    end
endmodule

// File: rtl/mpu_seq_engine.sv
// mpu_seq_engine: multi-cycle matrix unit, one element / MAC step per clock.
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : start/operation/size/factor/matrix_a/matrix_b in,
//                    busy/done/error/overflow/result out
module mpu_seq_engine
    import mpu_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    mpu_seq_engine_if.slave bus
);
    localparam int SW = $clog2(N + 1);
    localparam int IW = 2 * W + $clog2(N);
    localparam int MW = N * N * W;

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [SW-1:0]        size_q, size_d, r_q, r_d, c_q, c_d, k_q, k_d;
    logic signed [W-1:0]  factor_q, factor_d;
    logic [MW-1:0]        a_q, a_d, b_q, b_d, result_q, result_d;
    logic signed [IW-1:0] acc_q, acc_d;
    logic                 err_q, err_d, ovf_q, ovf_d;

    // Operand fetch for the current (r,c,k) position.
    logic signed [W-1:0]  a_rc, b_rc, a_cr, a_rk, b_kc;
    assign a_rc = a_q[idx(int'(r_q), int'(c_q), N, W) +: W];
    assign b_rc = b_q[idx(int'(r_q), int'(c_q), N, W) +: W];
    assign a_cr = a_q[idx(int'(c_q), int'(r_q), N, W) +: W];
    assign a_rk = a_q[idx(int'(r_q), int'(k_q), N, W) +: W];
    assign b_kc = b_q[idx(int'(k_q), int'(c_q), N, W) +: W];

    logic signed [IW-1:0] ew, acc_next, sat_in;
    logic signed [W-1:0]  sat_out;
    logic                 sat_ovf;

    always_comb begin
        ew = '0;
        case (op_q)
            OP_ADD:       ew = IW'(a_rc) + IW'(b_rc);
            OP_SUB:       ew = IW'(a_rc) - IW'(b_rc);
            OP_IMUL:      ew = IW'(a_rc) * IW'(factor_q);
            OP_OPP:       ew = -IW'(a_rc);
            OP_TRANSPOSE: ew = IW'(a_cr);
            default:      ew = '0;
        endcase
    end

    // Accumulator restarts at k==0 so no separate clear cycle is needed.
    assign acc_next = ((k_q == '0) ? '0 : acc_q) + IW'(a_rk) * IW'(b_kc);
    assign sat_in   = (op_q == OP_MUL) ? acc_next : ew;

    mpu_saturate #(.W(W), .IW(IW)) u_sat (
        .din_i  (sat_in),
        .dout_o (sat_out),
        .ovf_o  (sat_ovf)
    );

    logic last_k, last_c, last_r, cmd_bad;
    assign last_k  = (op_q != OP_MUL) || (k_q == size_q - SW'(1));
    assign last_c  = (c_q == size_q - SW'(1));
    assign last_r  = (r_q == size_q - SW'(1));
    assign cmd_bad = (bus.size == '0) || (bus.size > SW'(N)) || !op_valid(bus.operation);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        size_d   = size_q;
        factor_d = factor_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        c_d      = c_q;
        k_d      = k_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = bus.operation;
                    size_d   = bus.size;
                    factor_d = bus.factor;
                    a_d      = bus.matrix_a;
                    b_d      = bus.matrix_b;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = cmd_bad;
                    r_d      = '0;
                    c_d      = '0;
                    k_d      = '0;
                    state_d  = cmd_bad ? DONE : RUN;
                end
            end
            RUN: begin
                if (op_q == OP_MUL) acc_d = acc_next;
                if (last_k) begin
                    result_d[idx(int'(r_q), int'(c_q), N, W) +: W] = sat_out;
                    ovf_d = ovf_q | sat_ovf;
                    k_d   = '0;
                    if (last_c) begin
                        c_d = '0;
                        if (last_r) begin
                            r_d     = '0;
                            state_d = DONE;
                        end else begin
                            r_d = r_q + SW'(1);
                        end
                    end else begin
                        c_d = c_q + SW'(1);
                    end
                end else begin
                    k_d = k_q + SW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            size_q   <= '0;
            factor_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            size_q   <= size_d;
            factor_q <= factor_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            c_q      <= c_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.error    = err_q;
    assign bus.overflow = ovf_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_mpu_seq_engine.sv
// Directed bench for mpu_seq_engine with an expected-result queue.
module tb_mpu_seq_engine;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int SW = $clog2(N + 1);
    localparam int MW = N * N * W;

    typedef struct {
        logic [MW-1:0] res;
        logic          err;
        logic          ovf;
        int            lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   A [N][N];
    int   B [N][N];
    exp_t q [$];

    mpu_seq_engine_if #(.N(N), .W(W)) bus ();

    mpu_seq_engine #(.N(N), .W(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] pack(input int m [N][N]);
        logic [MW-1:0] p;
        int            v;
        p = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                v = m[r][c];
                p[(r*N+c)*W +: W] = v[W-1:0];
            end
        return p;
    endfunction

    function automatic exp_t model(input int op, input int sz, input int fac);
        exp_t e;
        int   v;
        e.res = '0;
        e.ovf = 1'b0;
        e.err = (sz < 1) || (sz > N) || (op == 5) || (op == 7);
        e.lat = 1;
        if (e.err) return e;
        e.lat = (op == 6) ? sz*sz*sz + 1 : sz*sz + 1;
        for (int r = 0; r < sz; r++)
            for (int c = 0; c < sz; c++) begin
                case (op)
                    0: v = A[r][c] + B[r][c];
                    1: v = A[r][c] - B[r][c];
                    2: v = A[r][c] * fac;
                    3: v = -A[r][c];
                    4: v = A[c][r];
                    default: begin
                        v = 0;
                        for (int k = 0; k < sz; k++) v += A[r][k] * B[k][c];
                    end
                endcase
                if (v > 127)  begin v = 127;  e.ovf = 1'b1; end
                if (v < -128) begin v = -128; e.ovf = 1'b1; end
                e.res[(r*N+c)*W +: W] = v[W-1:0];
            end
        return e;
    endfunction

    task automatic issue(input int op, input int sz, input int fac);
        q.push_back(model(op, sz, fac));
        @(negedge clock);
        bus.start     = 1'b1;
        bus.operation = op[2:0];
        bus.size      = sz[SW-1:0];
        bus.factor    = fac[W-1:0];
        bus.matrix_a  = pack(A);
        bus.matrix_b  = pack(B);
    endtask

    // poke_at > 0: pulse start with junk operands at that edge (must be ignored).
    task automatic wait_done(input string tag, input int poke_at);
        int   edges;
        logic got;
        exp_t e;
        edges = 0;
        got   = 1'b0;
        while (edges < 200) begin
            @(posedge clock);
            edges++;
            #1;
            if (edges == 1) begin
                bus.start = 1'b0;
                chk({tag, "-busy"}, MW'(bus.busy), MW'(1));
            end
            if (poke_at > 0 && edges == poke_at) begin
                bus.start     = 1'b1;
                bus.operation = 3'd1;
                bus.matrix_a  = {MW{1'b1}};
            end
            if (poke_at > 0 && edges == poke_at + 1) bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "-done_seen"}, MW'(got), MW'(1));
        e = q.pop_front();
        if (got) begin
            chk({tag, "-latency"}, MW'(edges), MW'(e.lat));
            chk({tag, "-result"}, bus.result, e.res);
            chk({tag, "-error"}, MW'(bus.error), MW'(e.err));
            chk({tag, "-overflow"}, MW'(bus.overflow), MW'(e.ovf));
            @(posedge clock);
            #1;
            chk({tag, "-done_pulse"}, MW'({bus.done, bus.busy}), MW'(0));
        end
    endtask

    task automatic fill(input int av, input int bv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                A[r][c] = av;
                B[r][c] = bv;
            end
    endtask

    initial begin
        int   nodone;
        bus.start     = 1'b0;
        bus.operation = '0;
        bus.size      = '0;
        bus.factor    = '0;
        bus.matrix_a  = '0;
        bus.matrix_b  = '0;
        fill(0, 0);
        repeat (2) @(negedge clock);
        chk("reset-busy", MW'(bus.busy), MW'(0));
        chk("reset-done", MW'(bus.done), MW'(0));
        chk("reset-flags", MW'({bus.error, bus.overflow}), MW'(0));
        chk("reset-result", bus.result, '0);
        reset_n = 1'b1;

        // ADD saturating
        fill(100, 50);
        issue(0, 3, 0);
        wait_done("add", 0);

        // SUB 2x2
        fill(0, 0);
        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 4; B[0][1] = 3; B[1][0] = 2; B[1][1] = 1;
        issue(1, 2, 0);
        wait_done("sub", 0);

        // MUL 2x2
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
        issue(6, 2, 0);
        wait_done("mul2", 0);

        // MUL 5x5 identity x matrix
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                A[r][c] = (r == c) ? 1 : 0;
                B[r][c] = ((r*7 + c*3) % 50) - 20;
            end
        issue(6, 5, 0);
        wait_done("mul5", 0);

        // OPP of most negative value
        fill(0, 0);
        A[0][0] = -128;
        issue(3, 1, 0);
        wait_done("opp", 0);

        // TRANSPOSE full size
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) A[r][c] = r*5 + c;
        issue(4, 5, 0);
        wait_done("transpose", 0);

        // IMUL with mixed saturation
        issue(2, 4, -7);
        wait_done("imul", 0);

        // invalid commands
        fill(3, 4);
        issue(0, 0, 0);
        wait_done("size0", 0);
        issue(0, 6, 0);
        wait_done("size6", 0);
        issue(5, 2, 0);
        wait_done("op5", 0);
        issue(7, 2, 0);
        wait_done("op7", 0);

        // start during RUN is ignored
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                A[r][c] = 10;
                B[r][c] = r + c;
            end
        issue(0, 4, 0);
        wait_done("ignore_start", 3);

        // reset mid-MUL aborts
        fill(2, 3);
        issue(6, 5, 0);
        void'(q.pop_back());
        repeat (40) begin
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("abort-busy", MW'(bus.busy), MW'(0));
        chk("abort-result", bus.result, '0);
        chk("abort-flags", MW'({bus.error, bus.overflow}), MW'(0));
        nodone = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.done) nodone++;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (bus.done) nodone++;
        end
        chk("abort-no_done", MW'(nodone), MW'(0));

        fill(64, 0);
        issue(2, 5, -2);
        wait_done("imul_after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
